mmio_uart_tx: RTL and testbench

//  Memory-mapped UART transmitter on the SingleCycleCPU data-memory bus (consumes memWrite/ALUOut/writeData).
//  CPU stores bytes to a TXDATA register; the block buffers them in a FIFO and serialises them 8N1 on tx.

---
 rtl/mmio_uart_tx.sv | 175 +++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a TX FIFO and a pollable STATUS word.
// Define UART_TX_PARITY_EN to add an even-parity bit after the data bits.
module mmio_uart_tx #(
  parameter int unsigned CLK_DIV    = 16,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [31:0] BASE_ADDR  = 32'hFFFF0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memWrite,
  input  logic        memRead,
  input  logic [31:0] addr,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        tx,
  output logic        tx_busy
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned NW = PW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t          state_q, state_n;
  logic [CW-1:0]   cnt_q, cnt_n;
  logic [2:0]      bit_q, bit_n;
  logic [7:0]      byte_q, byte_n;
  logic            tx_q, tx_n;
  logic            busy_q, busy_n;
  logic            ovf_q;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [NW-1:0]   count_q, count_n;

  logic hit, wr_tx, wr_st, rd_st, full, empty, wrap;
  logic push, pop, ovf_set, ovf_clr;
  logic unused_wdata;

  // Bus decode and status readback
  always_comb begin
    hit      = (addr[31:3] == BASE_ADDR[31:3]);
    wr_tx    = memWrite && hit && (addr[2:0] == 3'd0);
    wr_st    = memWrite && hit && (addr[2:0] == 3'd4);
    rd_st    = memRead  && hit && (addr[2:0] == 3'd4);
    full     = (count_q == NW'(FIFO_DEPTH));
    empty    = (count_q == '0);
    readData = rd_st ? {28'b0, ovf_q, busy_q, empty, full} : 32'b0;
  end

  assign unused_wdata = ^writeData[31:8];

  // Transmit FSM next-state, FIFO pop and registered line value
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    bit_n   = bit_q;
    byte_n  = byte_q;
    pop     = 1'b0;
    tx_n    = 1'b1;
    wrap    = (cnt_q == CW'(CLK_DIV - 1));
    if (state_q != S_IDLE) cnt_n = wrap ? '0 : cnt_q + CW'(1);
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          byte_n  = mem[rd_ptr];
          state_n = S_START;
          cnt_n   = '0;
        end
      end
      S_START: begin
        if (wrap) begin
          state_n = S_DATA;
          bit_n   = 3'd0;
        end
      end
      S_DATA: begin
        if (wrap) begin
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_n = S_PARITY;
`else
            state_n = S_STOP;
`endif
          end else begin
            bit_n = bit_q + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (wrap) state_n = S_STOP;
      end
`endif
      S_STOP: begin
        if (wrap) begin
          if (!empty) begin
            pop     = 1'b1;
            byte_n  = mem[rd_ptr];
            state_n = S_START;
          end else begin
            state_n = S_IDLE;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
    case (state_n)
      S_START:  tx_n = 1'b0;
      S_DATA:   tx_n = byte_n[bit_n];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_n = ^byte_n;
`endif
      default:  tx_n = 1'b1;
    endcase
  end

  // FIFO bookkeeping; a pop in the same cycle frees room for the push
  always_comb begin
    push    = wr_tx && (!full || pop);
    ovf_set = wr_tx && full && !pop;
    ovf_clr = wr_st && writeData[3];
    case ({push, pop})
      2'b10:   count_n = count_q + NW'(1);
      2'b01:   count_n = count_q - NW'(1);
      default: count_n = count_q;
    endcase
    busy_n = (state_n != S_IDLE) || (count_n != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      bit_q   <= bit_n;
      byte_q  <= byte_n;
      tx_q    <= tx_n;
      busy_q  <= busy_n;
      count_q <= count_n;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (ovf_clr)      ovf_q <= 1'b0;
      else if (ovf_set) ovf_q <= 1'b1;
    end
  end

  // Storage array needs no reset; pointers define validity
  always_ff @(posedge clk) begin
    if (!rst && push) mem[wr_ptr] <= writeData[7:0];
  end

  assign tx      = tx_q;
  assign tx_busy = busy_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: frame-timeline model plus literal spot checks.
module tb_mmio_uart_tx;

  localparam int unsigned CD    = 16;
  localparam int unsigned DEPTH = 8;
  localparam logic [31:0] BASE  = 32'hFFFF0000;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_LEN = 11 * CD;
`else
  localparam int FRAME_LEN = 10 * CD;
`endif

  logic        clk;
  logic        rst;
  logic        memWrite;
  logic        memRead;
  logic [31:0] addr;
  logic [31:0] writeData;
  logic [31:0] readData;
  logic        tx;
  logic        tx_busy;

  int checks;
  int failures;

  mmio_uart_tx #(.CLK_DIV(CD), .FIFO_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .memWrite(memWrite), .memRead(memRead), .addr(addr),
    .writeData(writeData), .readData(readData), .tx(tx), .tx_busy(tx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: queued bytes plus the age of the frame on the line
  logic [7:0] q[$];
  logic [7:0] cur;
  bit         active;
  int         elapsed;
  bit         ovf;
  bit         mvalid;

  initial begin
    active = 0; elapsed = 0; ovf = 0; mvalid = 0; cur = 8'h00;
  end

  function automatic logic frame_bit(input logic [7:0] b, input int e);
    int idx;
    idx = e / int'(CD);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
`ifdef UART_TX_PARITY_EN
    if (idx == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      active = 0;
      elapsed = 0;
      ovf = 0;
      mvalid = 1;
    end else begin
      if (active) begin
        elapsed++;
        if (elapsed == FRAME_LEN) active = 0;
      end
      if (!active && q.size() > 0) begin
        cur = q.pop_front();
        active = 1;
        elapsed = 0;
      end
      if (memWrite && addr[31:3] == BASE[31:3]) begin
        if (addr[2:0] == 3'd0) begin
          if (q.size() < int'(DEPTH)) q.push_back(writeData[7:0]);
          else ovf = 1;
        end else if (addr[2:0] == 3'd4 && writeData[3]) begin
          ovf = 0;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    logic        e_tx, e_busy;
    logic [31:0] e_rd;
    if (mvalid) begin
      e_tx   = active ? frame_bit(cur, elapsed) : 1'b1;
      e_busy = active || (q.size() > 0);
      e_rd   = 32'h0;
      if (memRead && addr[31:3] == BASE[31:3] && addr[2:0] == 3'd4)
        e_rd = {28'b0, ovf, e_busy, q.size() == 0, q.size() == int'(DEPTH)};
      check("model_tx", 32'(tx), 32'(e_tx));
      check("model_busy", 32'(tx_busy), 32'(e_busy));
      check("model_readData", readData, e_rd);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    memWrite = 1'b1; addr = a; writeData = d;
    step();
    memWrite = 1'b0; addr = 32'h0; writeData = 32'h0;
  endtask

  task automatic rd_status(input string name, input logic [31:0] exp);
    memRead = 1'b1; addr = BASE + 32'd4;
    #1;
    check(name, readData, exp);
    memRead = 1'b0; addr = 32'h0;
  endtask

  initial begin
    int lows;
    int r;
    checks = 0; failures = 0;
    rst = 1'b1; memWrite = 1'b0; memRead = 1'b0; addr = 32'h0; writeData = 32'h0;

    // Reset state
    step(); step();
    rst = 1'b0;
    check("reset_tx", 32'(tx), 32'h1);
    check("reset_busy", 32'(tx_busy), 32'h0);
    rd_status("reset_status", 32'h2);

    // Single 0x55 frame timing
    wr(BASE, 32'hABCDEF55);
    step();
    check("start_bit", 32'(tx), 32'h0);
    repeat (CD) step();
    check("data_bit0", 32'(tx), 32'h1);
    repeat (CD) step();
    check("data_bit1", 32'(tx), 32'h0);
    repeat (FRAME_LEN - 2 * CD - 1) step();
    check("stop_busy", 32'(tx_busy), 32'h1);
    step();
    check("idle_tx", 32'(tx), 32'h1);
    check("idle_busy", 32'(tx_busy), 32'h0);

    // Overflow on ten back-to-back writes, then clear
    for (int i = 0; i < 10; i++) wr(BASE, $urandom);
    rd_status("overflow_status", 32'hD);
    wr(BASE + 32'd4, 32'h8);
    rd_status("overflow_cleared", 32'h5);
    repeat (10 * FRAME_LEN + 20) step();
    check("drained_busy", 32'(tx_busy), 32'h0);

`ifdef UART_TX_PARITY_EN
    wr(BASE, 32'h07);
    step();
    repeat (9 * CD) step();
    check("parity_07", 32'(tx), 32'h1);
    repeat (2 * CD - 1) step();
    check("frame176_busy", 32'(tx_busy), 32'h1);
    step();
    check("frame176_idle", 32'(tx_busy), 32'h0);
    wr(BASE, 32'h03);
    step();
    repeat (9 * CD) step();
    check("parity_03", 32'(tx), 32'h0);
    repeat (3 * CD) step();
`endif

    // Reset during data bit 4 with a second byte queued
    wr(BASE, 32'h3C);
    wr(BASE, 32'hA5);
    repeat (CD + 4 * CD + 4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_tx", 32'(tx), 32'h1);
    lows = 0;
    for (int i = 0; i < 2 * FRAME_LEN; i++) begin
      step();
      if (tx == 1'b0) lows++;
    end
    check("abort_no_start", 32'(lows), 32'h0);
    rd_status("abort_status", 32'h2);

    // Out-of-window and reserved-offset accesses
    wr(BASE + 32'd8, 32'h11);
    wr(32'h0, 32'h22);
    wr(BASE + 32'd1, 32'h33);
    step();
    check("nohit_tx", 32'(tx), 32'h1);
    rd_status("nohit_status", 32'h2);
    addr = BASE + 32'd4; memRead = 1'b0;
    #1;
    check("noread_data", readData, 32'h0);
    addr = 32'h0; memRead = 1'b1;
    #1;
    check("miss_data", readData, 32'h0);
    memRead = 1'b0;

    // Randomized bus traffic checked by the model every cycle
    for (int i = 0; i < 6000; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 2) begin
        memWrite = 1'b1; addr = BASE; writeData = $urandom;
      end else if (r < 4) begin
        memWrite = 1'b1; addr = BASE + 32'd4; writeData = $urandom;
      end else if (r < 5) begin
        memWrite = 1'b1; addr = BASE + 32'($urandom_range(0, 7)); writeData = $urandom;
      end else if (r < 30) begin
        memRead = 1'b1;
        addr = (r < 20) ? BASE + 32'd4 : ((r < 25) ? BASE + 32'($urandom_range(0, 15)) : $urandom);
      end
      rst = ($urandom_range(0, 1499) == 0);
      step();
      memWrite = 1'b0; memRead = 1'b0; addr = 32'h0; writeData = 32'h0; rst = 1'b0;
    end

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
